fir_bram_sequencer: RTL

- Sequences the audio clean-up path: loads a frame of DEPTH distorted 8-bit samples into the single-port sample BRAM, then reads them back one at a time.
- Builds the 5-tap window (x[i-4]..x[i]) in a local history register and drives the fixed-latency filter with it.
- Writes each filtered result back in place at address i.
- Sole owner of the BRAM port; the filter is purely a datapath slave.

---
 rtl/fir_bram_sequencer_pkg.sv | 22 ++
 rtl/fir_bram_sequencer_tap_window.sv | 41 ++++
 rtl/fir_bram_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fir_bram_sequencer_pkg.sv
// Shared types and constants for the FIR BRAM sequencer.
//   state_t  : sequencer FSM states
//   NUM_TAPS : filter window length
//   sample_t : default-width audio sample
package fir_seq_pkg;

  localparam int unsigned NUM_TAPS = 5;
  localparam int unsigned SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD,
    RWAIT,
    FILT,
    WB,
    DONE
  } state_t;

endpackage

// File: rtl/fir_bram_sequencer_tap_window.sv
// 5-deep sample history feeding the filter window.
// Ports: clk, rst (async active-high), clr (zero all slots), shift (push din
// into slot 0), repl (with shift: load din into every slot), din, taps
// (flattened window, [DATA_W-1:0] = newest sample, top slice = oldest).
module fir_tap_window
  import fir_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         shift,
  input  logic                         repl,
  input  logic [DATA_W-1:0]            din,
  output logic [NUM_TAPS*DATA_W-1:0]   taps
);

  logic [DATA_W-1:0] hist [NUM_TAPS];

  // History register: clear at frame start, shift or replicate on each read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) hist[k] <= '0;
    end else if (clr) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) hist[k] <= '0;
    end else if (shift) begin
      if (repl) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) hist[k] <= din;
      end else begin
        hist[0] <= din;
        for (int unsigned k = 1; k < NUM_TAPS; k++) hist[k] <= hist[k-1];
      end
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_taps
    assign taps[g*DATA_W +: DATA_W] = hist[g];
  end

endmodule

// File: rtl/fir_bram_sequencer.sv
// Frame sequencer for the audio clean-up path: loads DEPTH samples into the
// single-port sample BRAM, then for each index reads the sample back, builds
// the 5-tap window, waits FILT_LAT cycles for the filter and writes the result
// back in place. Optional macro FIR_SEQ_EDGE_REPLICATE_EN replicates x[0] into
// the missing leading taps instead of zero-padding.
// Ports: clk, rst (async active-high), start; s_data/s_valid/s_ready load
// stream; bram_addr/bram_we/bram_wdata/bram_rdata BRAM port; taps/taps_valid/
// filt_out filter interface; busy, done, idx status.
module fir_bram_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned FILT_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [ADDR_W-1:0]           bram_addr,
  output logic                        bram_we,
  output logic [DATA_W-1:0]           bram_wdata,
  input  logic [DATA_W-1:0]           bram_rdata,
  output logic [NUM_TAPS*DATA_W-1:0]  taps,
  output logic                        taps_valid,
  input  logic [DATA_W-1:0]           filt_out,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W-1:0]           idx
);

  localparam int unsigned      CNT_W    = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FILT_LAT - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               load_last;
  logic               win_clr_c;
  logic               win_shift_c;
  logic               win_repl_c;

  // Window controls line up with the FSM edge that leaves IDLE / RWAIT
  assign win_clr_c   = (state == IDLE) && start;
  assign win_shift_c = (state == RWAIT);
`ifdef FIR_SEQ_EDGE_REPLICATE_EN
  assign win_repl_c  = (state == RWAIT) && (idx == '0);
`else
  assign win_repl_c  = 1'b0;
`endif

  fir_tap_window #(
    .DATA_W (DATA_W)
  ) u_window (
    .clk   (clk),
    .rst   (rst),
    .clr   (win_clr_c),
    .shift (win_shift_c),
    .repl  (win_repl_c),
    .din   (bram_rdata),
    .taps  (taps)
  );

  // Sequencer FSM; outputs are registered for the state being entered.
  // The last load beat's write lands one cycle later, so LOAD holds one
  // extra cycle (load_last) before the BRAM port is turned to reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      bram_addr  <= '0;
      bram_we    <= 1'b0;
      bram_wdata <= '0;
      taps_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      load_last  <= 1'b0;
    end else begin
      bram_we    <= 1'b0;
      taps_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            idx       <= '0;
            s_ready   <= 1'b1;
            busy      <= 1'b1;
            load_last <= 1'b0;
          end
        end
        LOAD: begin
          if (load_last) begin
            state     <= RD;
            idx       <= '0;
            bram_addr <= '0;
            load_last <= 1'b0;
          end else if (s_valid && s_ready) begin
            bram_we    <= 1'b1;
            bram_addr  <= idx;
            bram_wdata <= s_data;
            if (idx == LAST_IDX) begin
              load_last <= 1'b1;
              s_ready   <= 1'b0;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        RD: begin
          state <= RWAIT;
        end
        RWAIT: begin
          state      <= FILT;
          cnt        <= '0;
          taps_valid <= 1'b1;
        end
        FILT: begin
          if (cnt == LAST_CNT) begin
            state      <= WB;
            bram_we    <= 1'b1;
            bram_addr  <= idx;
            bram_wdata <= filt_out;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WB: begin
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= RD;
            idx       <= idx + ADDR_W'(1);
            bram_addr <= idx + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
